// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM feeding a small instruction buffer, with head decode.
// Define FETCH_PREFETCH_EN for a 2-deep buffer (prefetch while stalled); default depth is 1.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [4:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic        illegal
);
`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] buf_inst_q [2];
    logic [31:0] buf_inst_d [2];
    logic [31:0] buf_pc_q [2];
    logic [31:0] buf_pc_d [2];
    logic        pending, issue, push, pop;
    logic [1:0]  wr_idx;
    logic [31:0] target;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // An ack coinciding with a redirect in WAIT completes the request, so no FLUSH is needed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = issue ? WAIT : FETCH;
            WAIT:    state_d = imem_ack ? FETCH : (redirect ? FLUSH : WAIT);
            FLUSH:   state_d = imem_ack ? FETCH : FLUSH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pending   = (state_q == WAIT) || (state_q == FLUSH);
        issue     = (state_q == FETCH) && !redirect && (({1'b0, count_q} + {2'b00, pending}) < 3'(DEPTH));
        imem_req  = issue || pending;
        imem_addr = pending ? req_addr_q : fetch_pc_q;
    end

    always_comb begin
        inst_valid = (count_q != 2'd0) && !redirect;
        inst       = inst_valid ? buf_inst_q[0] : 32'd0;
        inst_pc    = inst_valid ? buf_pc_q[0] : 32'd0;
        opcode     = inst[6:2];
        func3      = inst[14:12];
        func7      = inst[31:25];
        illegal    = inst_valid && (inst[1:0] != 2'b11);
    end

    // Head lives in entry 0; a pop shifts entry 1 down before the new word lands behind it.
    always_comb begin
        target      = redirect_pc & ~32'h3;
        pop         = inst_valid && !stall;
        push        = (state_q == WAIT) && imem_ack && !redirect && ((count_q != 2'(DEPTH)) || pop);
        wr_idx      = count_q - {1'b0, pop};
        fetch_pc_d  = redirect ? target : (push ? req_addr_q + 32'd4 : fetch_pc_q);
        req_addr_d  = issue ? fetch_pc_q : req_addr_q;
        count_d     = redirect ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        buf_inst_d[0] = (push && wr_idx == 2'd0) ? imem_rdata : (pop ? buf_inst_q[1] : buf_inst_q[0]);
        buf_pc_d[0]   = (push && wr_idx == 2'd0) ? req_addr_q : (pop ? buf_pc_q[1] : buf_pc_q[0]);
        buf_inst_d[1] = (push && wr_idx == 2'd1) ? imem_rdata : buf_inst_q[1];
        buf_pc_d[1]   = (push && wr_idx == 2'd1) ? req_addr_q : buf_pc_q[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
            count_q    <= 2'd0;
            buf_inst_q <= '{default: 32'd0};
            buf_pc_q   <= '{default: 32'd0};
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            count_q    <= count_d;
            buf_inst_q <= buf_inst_d;
            buf_pc_q   <= buf_pc_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit; the expected stream is the sequential
// address run starting at the last reset or redirect target, fed by a randomized memory.
`timescale 1ns/1ps
module tb_fetch_unit;
`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk, rst;
    logic        imem_req, imem_ack, redirect, stall, inst_valid, illegal;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
    logic [4:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
        .redirect_pc(redirect_pc), .stall(stall), .inst_valid(inst_valid),
        .inst(inst), .inst_pc(inst_pc), .opcode(opcode), .func3(func3),
        .func7(func7), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    int          pops = 0;
    int          lat_max = 0;
    bit          mon_en = 0, lat_chk = 0, manual = 0, man_ack = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0000_0010;
        h = (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
        return {h[31:2], (a[5:2] == 4'hF) ? 2'b01 : 2'b11};
    endfunction

    task automatic sb_restart(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 32; i++) exp_q.push_back(pc + 32'(4 * i));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!imem_req && n < 50) begin cyc(); n++; end
        if (!imem_req) chk(name, 32'(imem_req), 32'd1);
    endtask

    task automatic wait_pops(input int target, input string name);
        int n = 0;
        while (pops < target && n < 200) begin cyc(); n++; end
        if (pops < target) chk(name, 32'(pops), 32'(target));
    endtask

    // Memory: acks after the request has been seen in WAIT, plus 0..lat_max extra cycles.
    initial begin
        int age = 0, lat = 0;
        imem_ack = 1'b0;
        imem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            if (manual) begin
                imem_ack = man_ack;
                imem_rdata = ~mem_word(imem_addr);
                age = 0;
            end else begin
                if (imem_ack) age = 0;
                imem_ack = 1'b0;
                age = imem_req ? age + 1 : 0;
                if (age == 1) lat = $urandom_range(lat_max, 0);
                if (imem_req && age >= 2 + lat) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                end
            end
        end
    end

    // Monitor: head must match the scoreboard front; requests must hold until acked.
    logic        prev_req = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    always @(negedge clk) begin
        logic [31:0] ew;
        if (rst && mon_en) begin
            if (redirect) chk("redirect_hides_head", 32'(inst_valid), 32'd0);
            if (prev_req && !prev_ack) begin
                chk("req_held", 32'(imem_req), 32'd1);
                chk("addr_held", imem_addr, prev_addr);
            end
            if (lat_chk && prev_ack) chk("ack_latency", 32'(inst_valid), 32'd1);
            if (inst_valid) begin
                ew = mem_word(exp_q[0]);
                chk("inst_pc", inst_pc, exp_q[0]);
                chk("inst", inst, ew);
                chk("opcode", 32'(opcode), 32'(ew[6:2]));
                chk("func3", 32'(func3), 32'(ew[14:12]));
                chk("func7", 32'(func7), 32'(ew[31:25]));
                chk("illegal", 32'(illegal), 32'(ew[1:0] != 2'b11));
                if (!stall) begin
                    void'(exp_q.pop_front());
                    exp_q.push_back(exp_q[$] + 32'd4);
                    pops++;
                end
            end
            prev_req = imem_req;
            prev_ack = imem_ack;
            prev_addr = imem_addr;
        end else begin
            prev_req = 1'b0;
            prev_ack = 1'b0;
        end
    end

    initial begin
        int n, acks, p0;
        logic [31:0] a, t;
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_pc", inst_pc, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        rst = 1'b1; sb_restart(RPC); mon_en = 1; lat_chk = 1;
        @(negedge clk); chk("idle_no_req", 32'(imem_req), 32'd0);
        @(negedge clk); chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RPC);
        wait_pops(3, "boot_pops");
        lat_chk = 0;

        n = 0;
        while (!inst_valid && n < 50) begin cyc(); n++; end
        stall = 1'b1; acks = 0;
        repeat (10) begin @(negedge clk); if (imem_ack) acks++; end
        chk("stall_acks", 32'(acks), 32'(DEPTH - 1));
        chk("stall_full_no_req", 32'(imem_req), 32'd0);
        cyc(); stall = 1'b0;
        wait_pops(pops + 4, "stall_resume");

        manual = 1; man_ack = 0;
        cyc(); wait_req("rd_req"); cyc();
        a = imem_addr;
        redirect = 1'b1; redirect_pc = 32'h0000_2002; sb_restart(32'h0000_2000);
        cyc(); redirect = 1'b0;
        chk("flush_req", 32'(imem_req), 32'd1);
        chk("flush_addr", imem_addr, a);
        cyc(); man_ack = 1;
        cyc(); man_ack = 0;
        @(negedge clk);
        chk("post_flush_req", 32'(imem_req), 32'd1);
        chk("post_flush_addr", imem_addr, 32'h0000_2000);
        manual = 0;
        wait_pops(pops + 2, "flush_resume");

        cyc(); manual = 1; man_ack = 0;
        wait_req("co_req_wait"); cyc();
        redirect = 1'b1; redirect_pc = 32'h0000_3000; man_ack = 1; sb_restart(32'h0000_3000);
        cyc(); redirect = 1'b0; man_ack = 0;
        @(negedge clk);
        chk("co_req", 32'(imem_req), 32'd1);
        chk("co_addr", imem_addr, 32'h0000_3000);
        chk("co_dropped", 32'(inst_valid), 32'd0);
        manual = 0;
        wait_pops(pops + 2, "co_resume");

        cyc(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8; sb_restart(32'hFFFF_FFF8);
        cyc(); redirect = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(imem_ack && imem_addr == 32'hFFFF_FFFC) && n < 100);
        n = 0;
        do begin @(negedge clk); n++; end while (!imem_req && n < 100);
        chk("wrap_addr", imem_addr, 32'h0);
        n = 0;
        while (!(inst_valid && inst_pc == 32'h0) && n < 100) begin @(negedge clk); n++; end
        chk("dec_inst", inst, 32'h0000_0013);
        chk("dec_opcode", 32'(opcode), 32'h4);
        chk("dec_func3", 32'(func3), 32'h0);
        chk("dec_func7", 32'(func7), 32'h0);
        chk("dec_legal", 32'(illegal), 32'h0);
        n = 0;
        while (!(inst_valid && inst_pc == 32'h4) && n < 100) begin @(negedge clk); n++; end
        chk("dec_illegal", 32'(illegal), 32'h1);

        cyc(); manual = 1; man_ack = 0;
        wait_req("mr_req_wait"); cyc();
        mon_en = 0; rst = 1'b0;
        #1;
        chk("mr_req", 32'(imem_req), 32'd0);
        chk("mr_addr", imem_addr, RPC);
        chk("mr_valid", 32'(inst_valid), 32'd0);
        chk("mr_inst", inst, 32'd0);
        chk("mr_pc", inst_pc, 32'd0);
        chk("mr_illegal", 32'(illegal), 32'd0);
        man_ack = 1;
        cyc(); cyc();
        rst = 1'b1; sb_restart(RPC); mon_en = 1;
        @(negedge clk);
        chk("mr_idle_req", 32'(imem_req), 32'd0);
        chk("mr_idle_valid", 32'(inst_valid), 32'd0);
        cyc(); man_ack = 0; manual = 0;
        @(negedge clk);
        chk("mr_fetch_req", 32'(imem_req), 32'd1);
        chk("mr_fetch_addr", imem_addr, RPC);
        chk("mr_ack_ignored", 32'(inst_valid), 32'd0);
        wait_pops(pops + 3, "mr_resume");

        lat_max = 2; p0 = pops;
        for (int i = 0; i < 600; i++) begin
            cyc();
            stall = ($urandom_range(3, 0) == 0);
            if ($urandom_range(24, 0) == 0) begin
                t = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
                redirect = 1'b1; redirect_pc = t; sb_restart(t & ~32'h3);
            end else begin
                redirect = 1'b0;
            end
        end
        cyc(); redirect = 1'b0; stall = 1'b0;
        repeat (20) cyc();
        chk("rand_progress", 32'(pops - p0 >= 60), 32'd1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
